// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types for the instruction fetch stage.
//   ProgramCounter : PC_W-bit word address (wraps modulo 2**PC_W)
//   Instruction    : 32-bit instruction word
//   fetch_state_t  : fetch control states IDLE / FETCH / HALT
// Optional feature macro used by this slice: FETCH_PERF_EN (performance counters).
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int PC_W   = 8;
  localparam int PERF_W = 16;

  typedef logic [PC_W-1:0] ProgramCounter;
  typedef logic [31:0]     Instruction;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage : instr_fetch_pkg

// File: rtl/fetch_perf_ctr.sv
// -----------------------------------------------------------------------------
// fetch_perf_ctr
// Saturating event counter used by the fetch stage statistics
// (only instantiated when FETCH_PERF_EN is defined).
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (clears the count)
//   clr    in  synchronous clear, takes priority over inc
//   inc    in  count one event this cycle
//   count  out current count, sticks at all-ones
// -----------------------------------------------------------------------------
module fetch_perf_ctr
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {PERF_W{1'b1}})) begin
      count_reg <= count_reg + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule : fetch_perf_ctr

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of a combinational instruction ROM. Owns the PC,
// presents {instruction, PC} to decode through a registered valid/ready
// output, and handles redirects from execute, decode backpressure, start
// and halt.
// Parameters:
//   IW        ROM index width (ROM holds 2**IW words, upper address bits alias)
//   RESET_PC  PC used after reset and on every start
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: leave IDLE/HALT and fetch from RESET_PC
//   rom_addr / rom_instr  ROM word address (= pc) and same-cycle ROM data
//   out_valid/out_ready   output handshake towards decode
//   out_instr / out_pc    fetched instruction and its PC
//   redir_valid/_target   redirect request from execute (highest priority)
//   halt / halted         stop request from decode / HALT state indicator
// Optional macro FETCH_PERF_EN adds:
//   perf_fetch_cnt        accepted handshakes (saturating)
//   perf_stall_cnt        cycles with out_valid && !out_ready (saturating)
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int            IW       = 4,
  parameter ProgramCounter RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output ProgramCounter     rom_addr,
  input  Instruction        rom_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output Instruction        out_instr,
  output ProgramCounter     out_pc,
  input  logic              redir_valid,
  input  ProgramCounter     redir_target,
  input  logic              halt,
`ifdef FETCH_PERF_EN
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt,
`endif
  output logic              halted
);

  // The ROM decodes only rom_addr[IW-1:0]; a wider index than the PC makes
  // no sense.
  generate
    if (IW < 1 || IW > PC_W) begin : g_iw_range_check
      $error("instr_fetch: IW must lie in 1..PC_W");
    end
  endgenerate

  fetch_state_t  state_reg;
  ProgramCounter pc_reg;
  logic          out_valid_reg;
  Instruction    out_instr_reg;
  ProgramCounter out_pc_reg;
  logic          halted_reg;

  // The output register can take a new word when it is empty or being drained.
  logic load_slot;
  assign load_slot = !out_valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_pc_reg    <= '0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
          end
        end

        FETCH: begin
          if (redir_valid) begin
            // Redirect flushes whatever decode has not yet taken, even if
            // out_ready is high this cycle; the target is fetched next cycle.
            pc_reg        <= redir_target;
            out_valid_reg <= 1'b0;
          end else if (halt) begin
            state_reg     <= HALT;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b1;
          end else if (load_slot) begin
            out_instr_reg <= rom_instr;
            out_pc_reg    <= pc_reg;
            out_valid_reg <= 1'b1;
            pc_reg        <= pc_reg + ProgramCounter'(1);
          end
        end

        HALT: begin
          if (start) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          halted_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr  = pc_reg;
  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_pc    = out_pc_reg;
  assign halted    = halted_reg;

`ifdef FETCH_PERF_EN
  // Counters restart whenever a start actually launches a new run.
  logic              perf_clr;
  logic [1:0]        perf_inc;
  logic [PERF_W-1:0] perf_cnt [2];

  assign perf_clr    = start && (state_reg != FETCH);
  assign perf_inc[0] = out_valid_reg && out_ready;
  assign perf_inc[1] = out_valid_reg && !out_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      fetch_perf_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (perf_inc[gi]),
        .count (perf_cnt[gi])
      );
    end
  endgenerate

  assign perf_fetch_cnt = perf_cnt[0];
  assign perf_stall_cnt = perf_cnt[1];
`endif

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch. The reference model describes the instruction
// stream decode should receive: consecutive PCs from the last start or
// redirect, wrapping at 8 bits, with ROM words aliasing every 16 addresses.
// Expected PCs are queued by the stimulus side; a negedge monitor pops one
// entry per accepted handshake and compares PC and instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int IW = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        redir_valid = 1'b0;
  logic [7:0]  redir_target = 8'h00;
  logic        halt = 1'b0;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // reference model state
  int         mode = M_IDLE;
  logic [7:0] exp_q[$];
  logic [7:0] next_pc = 8'h00;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  // ROM: word k holds 32'h1000_0000 + k, only the low IW address bits decode.
  assign rom_instr = 32'h1000_0000 + {28'd0, rom_addr[IW-1:0]};

  instr_fetch #(.IW(IW), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rom_addr     (rom_addr),
    .rom_instr    (rom_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .halt         (halt),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .halted       (halted)
  );

  function automatic logic [31:0] word_at(input logic [7:0] pc);
    return 32'h1000_0000 + (32'(pc) % 32'd16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Effect of the inputs sampled at the edge just taken.
  task automatic model_update(input logic s, input logic rv, input logic [7:0] t, input logic h);
    case (mode)
      M_RUN: begin
        if (rv) begin
          exp_q.delete();
          next_pc = t;
        end else if (h) begin
          mode = M_HALT;
          exp_q.delete();
        end
      end
      default: begin
        if (s) begin
          mode = M_RUN;
          exp_q.delete();
          next_pc = 8'h00;
        end
      end
    endcase
    if (mode == M_RUN) begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 8'd1;
      end
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance one edge.
  task automatic cycle(input logic s, input logic r, input logic rv,
                       input logic [7:0] t, input logic h);
    start = s; out_ready = r; redir_valid = rv; redir_target = t; halt = h;
    @(posedge clk);
    model_update(s, rv, t, h);
    #1;
  endtask

  // Monitor / scoreboard
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_pc;
  logic [31:0] stall_instr;

  always @(negedge clk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
    end else begin
      chk("halted_flag", {31'd0, halted}, {31'd0, (mode == M_HALT)});
      if (mode != M_RUN) chk("valid_while_stopped", {31'd0, out_valid}, 32'd0);
      if (stall_prev && mode == M_RUN) begin
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold_pc", {24'd0, out_pc}, {24'd0, stall_pc});
        chk("stall_hold_instr", out_instr, stall_instr);
      end
      if (out_valid && out_ready && !redir_valid && mode == M_RUN) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_txn", {24'd0, out_pc}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("txn_pc", {24'd0, out_pc}, {24'd0, e});
          chk("txn_instr", out_instr, word_at(e));
          delivered++;
          $display("TXN %0d pc=%02h instr=%08h", delivered, out_pc, out_instr);
        end
      end
      stall_prev  = out_valid && !out_ready && !redir_valid && !halt && (mode == M_RUN);
      stall_pc    = out_pc;
      stall_instr = out_instr;
    end
  end

  initial begin
    logic [7:0] frozen;

    // ---- reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", {24'd0, out_pc}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // ---- start, first word one cycle after start takes effect
    cycle(1, 1, 0, 8'h00, 0);
    chk("start_edge_valid", {31'd0, out_valid}, 32'd0);
    cycle(0, 1, 0, 8'h00, 0);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", {24'd0, out_pc}, 32'd0);
    chk("first_instr", out_instr, 32'h1000_0000);
    repeat (5) cycle(0, 1, 0, 8'h00, 0);
    chk("stream_pc5", {24'd0, out_pc}, 32'd5);

    // ---- backpressure at out_pc=5
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 8'h00, 0);
      chk("bp_pc", {24'd0, out_pc}, 32'd5);
      chk("bp_rom_addr", {24'd0, rom_addr}, 32'd6);
    end
    cycle(0, 1, 0, 8'h00, 0);
    chk("bp_release_pc", {24'd0, out_pc}, 32'd6);

    // ---- redirect while holding an instruction
    cycle(0, 0, 1, 8'h0C, 0);
    chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    cycle(0, 1, 0, 8'h00, 0);
    chk("redir_valid_after1", {31'd0, out_valid}, 32'd1);
    chk("redir_pc", {24'd0, out_pc}, 32'h0C);
    chk("redir_instr", out_instr, 32'h1000_000C);

    // ---- ROM alias past 15 and PC wrap past 255
    repeat (4) cycle(0, 1, 0, 8'h00, 0);
    chk("alias_pc", {24'd0, out_pc}, 32'h10);
    chk("alias_instr", out_instr, 32'h1000_0000);
    cycle(0, 1, 1, 8'hFD, 0);
    repeat (6) cycle(0, 1, 0, 8'h00, 0);
    chk("wrap_pc", {24'd0, out_pc}, 32'h02);
    chk("wrap_instr", out_instr, 32'h1000_0002);

    // ---- halt, redirect ignored while halted, restart
    cycle(0, 0, 0, 8'h00, 1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, out_valid}, 32'd0);
    frozen = rom_addr;
    cycle(0, 1, 1, 8'h33, 0);
    chk("halt_pc_frozen", {24'd0, rom_addr}, {24'd0, frozen});
    cycle(1, 1, 0, 8'h00, 0);
    chk("restart_halted", {31'd0, halted}, 32'd0);
    chk("restart_rom_addr", {24'd0, rom_addr}, 32'd0);
    cycle(0, 1, 0, 8'h00, 0);
    chk("restart_pc", {24'd0, out_pc}, 32'd0);
    chk("restart_valid", {31'd0, out_valid}, 32'd1);

    // ---- halt together with redirect: redirect wins
    cycle(0, 1, 1, 8'h40, 1);
    chk("halt_redir_halted", {31'd0, halted}, 32'd0);
    cycle(0, 1, 0, 8'h00, 0);
    chk("halt_redir_pc", {24'd0, out_pc}, 32'h40);

    // ---- randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic s, r, rv, h;
      logic [7:0] t;
      t = 8'($urandom);
      r = ($urandom_range(0, 99) < 70);
      if (mode == M_RUN) begin
        s  = ($urandom_range(0, 99) < 3);
        rv = ($urandom_range(0, 99) < 5);
        h  = ($urandom_range(0, 99) < 2);
      end else begin
        s  = ($urandom_range(0, 99) < 30);
        rv = ($urandom_range(0, 99) < 20);
        h  = ($urandom_range(0, 99) < 10);
      end
      cycle(s, r, rv, t, h);
    end

    // ---- asynchronous reset mid-stream
    cycle(1, 0, 0, 8'h00, 0);
    repeat (2) cycle(0, 0, 0, 8'h00, 0);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    chk("async_rst_pc", {24'd0, out_pc}, 32'd0);
    chk("async_rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    mode = M_IDLE;
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    mon_en = 1'b1;

    // ---- 4 stall cycles then 10 accepts
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    repeat (4) cycle(0, 0, 0, 8'h00, 0);
    repeat (10) cycle(0, 1, 0, 8'h00, 0);
    chk("perf_seq_pc", {24'd0, out_pc}, 32'd10);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", {16'd0, perf_fetch_cnt}, 32'd10);
    chk("perf_stall_cnt", {16'd0, perf_stall_cnt}, 32'd4);
`endif

    chk("enough_traffic", {31'd0, (delivered >= 300)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch
